// File: rtl/drive_cmd_arbiter.sv
// Drive-command core: prioritised source arbitration, deadman timeout, proximity
// inhibit, duty ramping across direction changes and a telemetry byte per state change.
module drive_cmd_arbiter #(
    parameter int NUM_SRC        = 2,
    parameter int DUTY_W         = 7,
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int RAMP_DIV       = 50_000,
    parameter int RAMP_STEP      = 1,
    parameter int PROX_STOP      = 12,
    parameter int PROX_HYST      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [3*NUM_SRC-1:0]     src_cmd,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic [3:0]               prox_level,
    input  logic [DUTY_W-1:0]        duty_target,
    output logic                     ina1,
    output logic                     inb1,
    output logic                     ina2,
    output logic                     inb2,
    output logic [DUTY_W-1:0]        duty1,
    output logic [DUTY_W-1:0]        duty2,
    output logic [2:0]               motor_stat,
    output logic                     inhibit,
    output logic [$clog2(NUM_SRC):0] owner,
    output logic                     tlm_valid,
    input  logic                     tlm_ready,
    output logic [7:0]               tlm_byte
);
    localparam int OW = $clog2(NUM_SRC) + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [OW-1:0]   NO_OWNER   = {OW{1'b1}};
    localparam logic [CW-1:0]   CNT_RELOAD = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]   DIV_MAX    = RW'(RAMP_DIV - 1);
    localparam logic [DUTY_W:0] STEP_W     = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [3:0]      PROX_SET   = 4'(PROX_STOP);
    localparam logic [3:0]      PROX_CLR   = 4'(PROX_STOP - PROX_HYST);

    localparam logic [2:0] MS_IDLE  = 3'b000;
    localparam logic [2:0] MS_FWD   = 3'b001;
    localparam logic [2:0] MS_LEFT  = 3'b010;
    localparam logic [2:0] MS_BRAKE = 3'b011;
    localparam logic [2:0] MS_RIGHT = 3'b100;
    localparam logic [2:0] MS_BACK  = 3'b101;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_RAMP_DOWN, S_SWITCH, S_BRAKE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        stat_q, stat_d, pend_q, pend_d, stat_prev_q;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     div_q, div_d;
    logic              inh_q, inh_d;
    logic              tlm_valid_q, tlm_valid_d;
    logic [7:0]        tlm_byte_q, tlm_byte_d;

    logic              win_any, cmd_legal, cmd_brake, cmd_motion, tick, timeout, force_inh;
    logic [OW-1:0]     win_idx;
    logic [2:0]        win_cmd, sw_cmd;
    logic [DUTY_W:0]   duty_w, tgt_w, up_w, dn_w;
    logic [DUTY_W-1:0] duty_track, duty_fall;

    function automatic logic is_motion(input logic [2:0] c);
        return (c == MS_FWD) || (c == MS_LEFT) || (c == MS_RIGHT) || (c == MS_BACK);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign src_ready[gi] = !((owner_q != NO_OWNER) && (OW'(gi) > owner_q));
        end
    endgenerate

    // Descending scan so the lowest ready index is the last to be written.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_cmd = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i] && src_ready[i]) begin
                win_any = 1'b1;
                win_idx = OW'(i);
                win_cmd = src_cmd[3*i +: 3];
            end
        end
    end

    assign inh_d = (prox_level >= PROX_SET) ? 1'b1 :
                   (prox_level <  PROX_CLR) ? 1'b0 : inh_q;

    // Command 000 is legal: it keeps the deadman alive without moving the drive.
    assign cmd_legal  = win_any && (win_cmd[2:1] != 2'b11);
    assign cmd_brake  = cmd_legal && (win_cmd == MS_BRAKE);
    assign cmd_motion = cmd_legal && is_motion(win_cmd) && !(win_cmd == MS_FWD && inh_d);

    assign tick      = (div_q == DIV_MAX);
    assign div_d     = tick ? '0 : div_q + RW'(1);
    assign timeout   = (cnt_q == '0) && (state_q != S_IDLE);
    assign force_inh = inh_d && (stat_q == MS_FWD);
    assign sw_cmd    = cmd_motion ? win_cmd : pend_q;

    assign duty_w     = {1'b0, duty_q};
    assign tgt_w      = {1'b0, duty_target};
    assign up_w       = duty_w + STEP_W;
    assign dn_w       = duty_w - STEP_W;
    assign duty_fall  = (duty_w < STEP_W) ? '0 : dn_w[DUTY_W-1:0];
    assign duty_track = (duty_w < tgt_w) ? ((up_w > tgt_w) ? duty_target : up_w[DUTY_W-1:0]) :
                        (duty_w > tgt_w) ? (((duty_w < STEP_W) || (dn_w < tgt_w)) ? duty_target
                                                                                  : dn_w[DUTY_W-1:0]) :
                        duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            stat_q      <= MS_IDLE;
            pend_q      <= MS_IDLE;
            stat_prev_q <= MS_IDLE;
            duty_q      <= '0;
            owner_q     <= NO_OWNER;
            cnt_q       <= '0;
            div_q       <= '0;
            inh_q       <= 1'b0;
            tlm_valid_q <= 1'b0;
            tlm_byte_q  <= '0;
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            pend_q      <= pend_d;
            stat_prev_q <= stat_q;
            duty_q      <= duty_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            inh_q       <= inh_d;
            tlm_valid_q <= tlm_valid_d;
            tlm_byte_q  <= tlm_byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        pend_d  = pend_q;
        duty_d  = duty_q;
        owner_d = owner_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        if (timeout) begin
            state_d = S_IDLE;
            stat_d  = MS_IDLE;
            duty_d  = '0;
            owner_d = NO_OWNER;
        end else if (force_inh) begin
            state_d = S_BRAKE;
            stat_d  = MS_BRAKE;
            duty_d  = '0;
        end else begin
            if (cmd_brake || cmd_motion || (cmd_legal && win_cmd == MS_IDLE)) begin
                cnt_d   = CNT_RELOAD;
                owner_d = cmd_brake ? NO_OWNER : win_idx;
            end
            if (cmd_brake) begin
                state_d = S_BRAKE;
                stat_d  = MS_BRAKE;
                duty_d  = '0;
            end else begin
                case (state_q)
                    S_IDLE, S_BRAKE: begin
                        if (cmd_motion) begin
                            state_d = S_RUN;
                            stat_d  = win_cmd;
                            duty_d  = '0;
                        end
                    end
                    S_RUN: begin
                        if (cmd_motion && (win_cmd != stat_q)) begin
                            state_d = S_RAMP_DOWN;
                            pend_d  = win_cmd;
                        end else if (tick) begin
                            duty_d = duty_track;
                        end
                    end
                    S_RAMP_DOWN: begin
                        if (cmd_motion) pend_d = win_cmd;
                        if (tick) duty_d = duty_fall;
                        if (duty_d == '0) state_d = S_SWITCH;
                    end
                    S_SWITCH: begin
                        // A pending forward may have become inhibited during the ramp-down.
                        if (sw_cmd == MS_FWD && inh_d) begin
                            state_d = S_BRAKE;
                            stat_d  = MS_BRAKE;
                        end else begin
                            state_d = S_RUN;
                            stat_d  = sw_cmd;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
        tlm_valid_d = tlm_valid_q;
        tlm_byte_d  = tlm_byte_q;
        if (stat_q != stat_prev_q) begin
            tlm_valid_d = 1'b1;
            tlm_byte_d  = {prox_level, stat_q, 1'b1};
        end else if (tlm_valid_q && tlm_ready) begin
            tlm_valid_d = 1'b0;
        end
    end

    always_comb begin
        {ina1, inb1, ina2, inb2} = 4'b0000;
        case (stat_q)
            MS_FWD:   {ina1, inb1, ina2, inb2} = 4'b1010;
            MS_BACK:  {ina1, inb1, ina2, inb2} = 4'b0101;
            MS_LEFT:  {ina1, inb1, ina2, inb2} = 4'b0110;
            MS_RIGHT: {ina1, inb1, ina2, inb2} = 4'b1001;
            default:  {ina1, inb1, ina2, inb2} = 4'b0000;
        endcase
    end

    assign duty1      = duty_q;
    assign duty2      = duty_q;
    assign motor_stat = stat_q;
    assign inhibit    = inh_q;
    assign owner      = owner_q;
    assign tlm_valid  = tlm_valid_q;
    assign tlm_byte   = tlm_byte_q;
endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Directed bench for drive_cmd_arbiter; telemetry bytes are checked against a queue
// of expected values filled as stimulus is applied.
module tb_drive_cmd_arbiter;
    localparam logic [2:0] C_FWD = 3'b001, C_LEFT = 3'b010, C_BRK = 3'b011,
                           C_RIGHT = 3'b100, C_BACK = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] src_valid;
    logic [5:0] src_cmd;
    logic [1:0] src_ready;
    logic [3:0] prox_level;
    logic [6:0] duty_target;
    logic       ina1, inb1, ina2, inb2;
    logic [6:0] duty1, duty2;
    logic [2:0] motor_stat;
    logic       inhibit;
    logic [1:0] owner;
    logic       tlm_valid;
    logic       tlm_ready;
    logic [7:0] tlm_byte;

    int         errors = 0;
    int         checks = 0;
    int         n, changes;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic [6:0] seq_q[$];
    logic [6:0] seq_exp[4] = '{7'd15, 7'd10, 7'd5, 7'd0};
    logic [6:0] prev_d;

    drive_cmd_arbiter #(
        .NUM_SRC(2), .DUTY_W(7), .TIMEOUT_CYCLES(100), .RAMP_DIV(4),
        .RAMP_STEP(5), .PROX_STOP(12), .PROX_HYST(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_cmd(src_cmd),
        .src_ready(src_ready), .prox_level(prox_level), .duty_target(duty_target),
        .ina1(ina1), .inb1(inb1), .ina2(ina2), .inb2(inb2),
        .duty1(duty1), .duty2(duty2), .motor_stat(motor_stat), .inhibit(inhibit),
        .owner(owner), .tlm_valid(tlm_valid), .tlm_ready(tlm_ready), .tlm_byte(tlm_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [2:0] c);
        src_valid = '0;
        src_valid[s] = 1'b1;
        src_cmd[3*s +: 3] = c;
        step();
        src_valid = '0;
    endtask

    task automatic wait_duty(input string tag, input logic [6:0] start, input logic [6:0] goal,
                             input int budget, output int nchg);
        logic [6:0] prev;
        int k;
        prev = start;
        nchg = 0;
        k = 0;
        forever begin
            if (duty1 !== prev) begin
                nchg++;
                prev = duty1;
            end
            if (duty1 === goal || k >= budget) break;
            step();
            k++;
        end
        check({tag, "_reach"}, duty1, goal);
        check({tag, "_duty2"}, duty2, goal);
    endtask

    // Telemetry scoreboard: one transfer per negedge where valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && tlm_valid && tlm_ready) begin
            $display("tlm transfer byte=%02h pending=%0d", tlm_byte, exp_q.size());
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL tlm_extra: observed=%02h expected=none", tlm_byte);
            end else begin
                exp_b = exp_q.pop_front();
                check("tlm_byte", tlm_byte, exp_b);
            end
        end
    end

    initial begin
        src_valid = '0;
        src_cmd = '0;
        prox_level = 4'd0;
        duty_target = 7'd20;
        tlm_ready = 1'b1;
        #12;
        check("rst_ina1", ina1, 0);
        check("rst_inb2", inb2, 0);
        check("rst_duty", duty1, 0);
        check("rst_stat", motor_stat, 0);
        check("rst_owner", owner, 2'b11);
        check("rst_ready", src_ready, 2'b11);
        check("rst_tlm_valid", tlm_valid, 0);
        check("rst_inhibit", inhibit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // fwd from idle, ramp to target
        send(0, C_FWD); exp_q.push_back(8'h03);
        check("t1_ina1", ina1, 1);
        check("t1_ina2", ina2, 1);
        check("t1_inb", {inb1, inb2}, 2'b00);
        check("t1_stat", motor_stat, 3'b001);
        check("t1_owner", owner, 0);
        check("t1_duty0", duty1, 0);
        check("t1_tlm_late", tlm_valid, 0);
        step();
        check("t1_tlm_valid", tlm_valid, 1);
        check("t1_tlm_byte", tlm_byte, 8'h03);
        wait_duty("t1_ramp", 7'd0, 7'd20, 40, changes);
        check("t1_ticks", changes, 4);
        repeat (8) step();
        check("t1_clamp", duty1, 20);

        // lockout of lower-priority source, brake releases ownership
        src_valid[1] = 1'b1; src_cmd[5:3] = C_BACK; #1;
        check("t2_ready", src_ready, 2'b01);
        step(); src_valid = '0;
        check("t2_locked_stat", motor_stat, 3'b001);
        check("t2_locked_owner", owner, 0);
        send(0, C_BRK); exp_q.push_back(8'h07);
        check("t2_brk_duty", duty1, 0);
        check("t2_brk_stat", motor_stat, 3'b011);
        check("t2_brk_owner", owner, 2'b11);
        check("t2_brk_pins", {ina1, inb1, ina2, inb2}, 4'b0000);
        send(1, C_BACK); exp_q.push_back(8'h0B);
        check("t2_back_stat", motor_stat, 3'b101);
        check("t2_back_owner", owner, 1);
        check("t2_back_pins", {ina1, inb1, ina2, inb2}, 4'b0101);
        check("t2_back_ready", src_ready, 2'b11);

        // simultaneous sources, then direction change with ramp-down
        send(0, C_BRK); exp_q.push_back(8'h07);
        src_valid = 2'b11; src_cmd = {C_BACK, C_FWD};
        step(); src_valid = '0; exp_q.push_back(8'h03);
        check("t3_both_stat", motor_stat, 3'b001);
        check("t3_both_owner", owner, 0);
        wait_duty("t3_up", 7'd0, 7'd20, 40, changes);
        send(0, C_RIGHT); exp_q.push_back(8'h09);
        check("t3_rdn_stat", motor_stat, 3'b001);
        prev_d = duty1; n = 0;
        while (duty1 !== 7'd0 && n < 40) begin
            step(); n++;
            if (duty1 !== prev_d) begin
                seq_q.push_back(duty1);
                prev_d = duty1;
            end
        end
        check("t3_rdn_len", seq_q.size(), 4);
        for (int i = 0; i < 4; i++) check("t3_rdn_step", seq_q[i], seq_exp[i]);
        check("t3_switch_stat", motor_stat, 3'b001);
        step();
        check("t3_right_stat", motor_stat, 3'b100);
        check("t3_right_pins", {ina1, inb1, ina2, inb2}, 4'b1001);
        wait_duty("t3_reup", 7'd0, 7'd20, 40, changes);
        check("t3_reup_ticks", changes, 4);

        // proximity inhibit with hysteresis
        send(0, C_BRK); exp_q.push_back(8'h07);
        send(0, C_FWD); exp_q.push_back(8'h03);
        wait_duty("t4_up", 7'd0, 7'd20, 40, changes);
        prox_level = 4'd12;
        step(); exp_q.push_back(8'hC7);
        check("t4_inh_duty", duty1, 0);
        check("t4_inh_stat", motor_stat, 3'b011);
        check("t4_inh_flag", inhibit, 1);
        check("t4_inh_pins", {ina1, inb1, ina2, inb2}, 4'b0000);
        step();
        prox_level = 4'd11;
        send(0, C_FWD);
        check("t4_fwd_ignored", motor_stat, 3'b011);
        check("t4_fwd_duty", duty1, 0);
        prox_level = 4'd10;
        step();
        check("t4_hyst_10", inhibit, 1);
        prox_level = 4'd9;
        step();
        check("t4_clear_9", inhibit, 0);
        send(0, C_FWD); exp_q.push_back(8'h93);
        check("t4_restart", motor_stat, 3'b001);
        step(); step();
        prox_level = 4'd0;

        // deadman timeout
        send(0, C_BRK); exp_q.push_back(8'h07);
        send(0, C_LEFT); exp_q.push_back(8'h05);
        check("t5_left_stat", motor_stat, 3'b010);
        check("t5_left_pins", {ina1, inb1, ina2, inb2}, 4'b0110);
        exp_q.push_back(8'h01);
        n = 0;
        while (motor_stat !== 3'b000 && n < 150) begin
            step(); n++;
        end
        check("t5_timeout_cycles", n, 100);
        check("t5_owner", owner, 2'b11);
        check("t5_duty", duty1, 0);
        check("t5_pins", {ina1, inb1, ina2, inb2}, 4'b0000);
        repeat (3) step();

        // telemetry overwrite while the consumer stalls
        tlm_ready = 1'b0;
        send(0, C_FWD);
        step(); step();
        check("t6_first_valid", tlm_valid, 1);
        check("t6_first_byte", tlm_byte, 8'h03);
        send(0, C_BRK); exp_q.push_back(8'h07);
        step(); step();
        check("t6_latest_byte", tlm_byte, 8'h07);
        repeat (3) step();
        check("t6_hold_valid", tlm_valid, 1);
        tlm_ready = 1'b1;
        step();
        tlm_ready = 1'b0;
        check("t6_cleared", tlm_valid, 0);

        // asynchronous reset mid-ramp
        tlm_ready = 1'b1;
        send(0, C_FWD); exp_q.push_back(8'h03);
        repeat (6) step();
        check("t7_midramp", (duty1 != 7'd0), 1);
        #3 rst_n = 1'b0;
        #1;
        check("t7_rst_duty", duty1, 0);
        check("t7_rst_stat", motor_stat, 0);
        check("t7_rst_owner", owner, 2'b11);
        check("t7_rst_pins", {ina1, inb1, ina2, inb2}, 4'b0000);
        check("t7_rst_ready", src_ready, 2'b11);
        check("t7_rst_tlm", tlm_valid, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/drive_cmd_arbiter.md
# drive_cmd_arbiter

Parametrised drive-command core that sits between the command decoders (IR remote, UART, future sources) and the H-bridge pins. It arbitrates N command sources with priority lockout and enforces a deadman timeout and a proximity-based forward inhibit. It ramps PWM duty on direction changes and emits a handshaked telemetry byte whenever drive state changes.

## Interface
Parameters:
- NUM_SRC, 2: number of command sources; index 0 has the highest priority.
- DUTY_W, 7: duty width.
- TIMEOUT_CYCLES, 25_000_000: deadman period in clk cycles (0.5 s at 50 MHz).
- RAMP_DIV, 50_000: clk cycles per ramp tick.
- RAMP_STEP, 1: duty change per ramp tick.
- PROX_STOP, 12: obstacle threshold on the 4-bit proximity level.
- PROX_HYST, 2: the inhibit clears when the level is below PROX_STOP-PROX_HYST.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  per-source command strobe.
- src_cmd  in  3*NUM_SRC  per-source command; source i occupies bits [3i+2:3i].
- src_ready  out  NUM_SRC  per-source accept.
- prox_level  in  4  saturated proximity level.
- duty_target  in  DUTY_W  cruise duty.
- ina1, inb1, ina2, inb2  out  1 each  H-bridge direction pins.
- duty1, duty2  out  DUTY_W each  PWM duty to the motor PWM generator.
- motor_stat  out  3  drive state code: 000 idle, 001 fwd, 010 left, 011 brake, 100 right, 101 back.
- inhibit  out  1  obstacle inhibit active.
- owner  out  $clog2(NUM_SRC)+1  owning source index; all-ones means no owner.
- tlm_valid  out  1  telemetry handshake valid.
- tlm_ready  in  1  telemetry handshake ready.
- tlm_byte  out  8  telemetry byte, {prox_level, motor_stat, 1'b1}.

Reset values:
- ina*/inb*, duty*, inhibit and tlm_valid are 0.
- motor_stat is 000.
- owner is all-ones.
- src_ready is all-ones.

## Operation
- Commands 110 and 111 are illegal. They are accepted and discarded, and have no other effect.
- Arbitration:
  - src_ready[i] is low only while another source owns the drive and i > owner.
  - Among sources with valid & ready in the same cycle, the lowest index wins. All other ready sources are consumed and discarded.
  - The winner becomes owner.
  - Ownership is released when the owner sends brake (011), on timeout, or on reset.
- Deadman:
  - A counter reloads to TIMEOUT_CYCLES-1 on each accepted legal command.
  - When the counter reaches 0 in a non-IDLE state: duty goes to 0, all dirs go to 0, motor_stat becomes 000, owner is released, and the state goes to IDLE.
- Inhibit:
  - Sets when prox_level >= PROX_STOP. Clears when prox_level < PROX_STOP-PROX_HYST.
  - If set while motor_stat is 001, the block forces brake (dirs 0, duty 0, motor_stat 011).
  - While inhibit is set, fwd commands are accepted but ignored. Other commands act normally.
- Direction map (ina=1/inb=0 drives a motor forward):
  - fwd: both motors forward.
  - back: both motors reverse.
  - left: motor1 reverse, motor2 forward.
  - right: motor1 forward, motor2 reverse.
  - brake and idle: all pins 0.
- States:
  - IDLE to RUN on a motion command. Dirs are set at once; duty ramps up from 0.
  - RUN to RAMP_DOWN on a different motion command. The pending command is stored; a newer command overwrites it.
  - RAMP_DOWN: duty decreases by RAMP_STEP per tick, saturating at 0. At 0 the state goes to SWITCH.
  - SWITCH lasts one cycle: dirs and motor_stat are loaded from the pending command, then the state goes to RUN.
  - RUN: duty moves toward duty_target by RAMP_STEP per tick and clamps exactly at the target. This tracks target changes in both directions.
  - Any state to BRAKE on a brake command, inhibit, or timeout (timeout goes to IDLE instead). This transition is immediate, with no ramp.
  - BRAKE to RUN on a motion command.
- Arithmetic: duty is computed with a one-bit-wider intermediate and clamped; it never wraps. duty1 always equals duty2.
- Telemetry:
  - Any change of motor_stat loads tlm_byte and sets tlm_valid.
  - tlm_valid clears on tlm_valid & tlm_ready.
  - If a new change occurs while valid is pending, tlm_byte is overwritten with the latest value and valid stays high.

## Timing
- An accepted command in cycle T updates owner, the state register and the dirs at edge T+1. Same-direction commands only reload the deadman counter.
- motor_stat updates at T+1 for IDLE to RUN and for brake. On a direction change it updates in the SWITCH cycle.
- tlm_valid rises one cycle after motor_stat changes.
- The ramp tick counter is free-running, wraps at RAMP_DIV-1, and is reset only by rst_n.
- Inhibit is evaluated every cycle. An inhibit-triggered brake appears at edge T+1 after prox_level crosses the threshold.
- Priority between simultaneous events in the same cycle, from highest: reset, timeout, inhibit, brake command, motion command.
- Reset asserted mid-ramp forces all outputs to their reset values asynchronously.

## Test plan
Bench parameters: TIMEOUT_CYCLES=100, RAMP_DIV=4, RAMP_STEP=5, duty_target=20.
- Src0 sends fwd for 1 cycle -> at T+1 ina1=ina2=1, motor_stat=001, owner=0. duty reaches 20 after 4 ticks. One telemetry byte 0x03 with prox=0.
- Src0 owns the drive; src1 sends back -> src_ready[1]=0 and the command has no effect. Src0 sends brake -> duty=0, motor_stat=011, owner released. Src1 back is then accepted.
- Fwd at duty 20, then right -> duty steps 15,10,5,0 at ticks, one SWITCH cycle, then motor1 forward/motor2 reverse and motor_stat=100. duty ramps back to 20.
- Fwd running, prox_level=12 -> next cycle duty=0, motor_stat=011, inhibit=1. Fwd commands are ignored. prox_level=9 clears inhibit; a new fwd restarts the drive.
- Left command, then no input for 100 cycles -> duty=0, all dirs 0, motor_stat=000, owner all-ones.
- tlm_ready held low across fwd then brake -> tlm_byte=0x07 (latest wins), tlm_valid stays high. Raising tlm_ready for 1 cycle clears valid.
